regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Sole owner of the register file write port.
- After reset, runs a clear sweep that writes zero to every register.
- Then arbitrates round-robin between NUM_REQ write-back requesters (e.g. ALU, load unit, link write) using valid/ready handshakes.
- Drives registered write enable, address and data to the register file.

Parameters:
- BUS_WIDTH, 16, register data width.
- DEPTH, 8, number of registers; ADDR_SIZE = $clog2(DEPTH).
- NUM_REQ, 3, number of write requesters (2..8).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req_valid  input  NUM_REQ  per-requester write request.
- req_addr  input  NUM_REQ*ADDR_SIZE  packed target addresses; requester i at [i*ADDR_SIZE +: ADDR_SIZE].
- req_data  input  NUM_REQ*BUS_WIDTH  packed write data; requester i at [i*BUS_WIDTH +: BUS_WIDTH].
- req_ready  output  NUM_REQ  one-hot grant (combinational).
- rf_wr_en  output  1  register file write enable (registered).
- rf_wr_addr  output  ADDR_SIZE  register file write address (registered).
- rf_wr_data  output  BUS_WIDTH  register file write data (registered).
- init_done  output  1  high once the clear sweep has completed.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=INIT, sweep counter=0, rr pointer=0.
  - rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, init_done=0.
  - req_ready=0.
- INIT state:
  - Each edge sets rf_wr_en=1, rf_wr_addr=counter, rf_wr_data=0, then counter+1.
  - Writes to addresses 0..DEPTH-1 occur on the first DEPTH edges after rst_n deasserts.
  - On the edge issuing address DEPTH-1: state<=ARB, init_done<=1.
  - req_ready is held at 0 throughout INIT.
- ARB state:
  - req_ready[i]=1 for exactly one i: the first valid requester scanning from the rr pointer upward, modulo NUM_REQ.
  - All req_ready bits are 0 when no request is valid.
  - req_ready depends only on state, pointer and req_valid; never on addr or data.
- Transfer:
  - Occurs when req_valid[i] && req_ready[i] at a rising edge.
  - That edge loads rf_wr_en=1, rf_wr_addr=req_addr[i], rf_wr_data=req_data[i].
  - Latency is 1 cycle from acceptance to write-port presentation.
  - Pointer<=(i+1) mod NUM_REQ.
- Idle edge (no transfer): rf_wr_en<=0; addr and data hold their previous values; pointer holds.
- Throughput: one write per cycle. Back-to-back transfers keep rf_wr_en high continuously.
- Requester rules: once valid is raised, hold valid, addr and data stable until accepted. The arbiter does not check this.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0; no requester waits more than NUM_REQ-1 grants.
- A requester dropping valid without acceptance is legal; that cycle's grant goes to the next valid requester per the scan.
- Reset mid-sweep or mid-transfer: all state returns to reset values immediately and the sweep restarts from address 0. A transfer in flight is lost.
- init_done stays 1 until the next reset.

Optional Feature:
- Macro: REGFILE_ARB_R0_PROTECT_EN.
- Defined:
  - An ARB-state transfer with addr==0 is accepted normally (ready, pointer advance).
  - The following cycle has rf_wr_en=0, so register 0 stays zero.
  - The INIT sweep still writes 0 to address 0.
- Undefined: writes to address 0 behave like any other address.

Test Plan:
- Reset then release, DEPTH=8 -> rf_wr_en=1 for 8 consecutive cycles with addr 0..7 and data 0x0000. init_done rises with the addr-7 write. req_ready stays 0 throughout.
- After init, only requester 1 valid with addr=3, data=0xBEEF -> req_ready=3'b010 the same cycle; next cycle rf_wr_en=1, addr=3, data=0xBEEF; then rf_wr_en=0.
- All three requesters held valid (addrs 1,2,4) -> grants 0,1,2,0,1,2 on successive cycles; rf_wr_en continuously 1; addresses follow the grant order.
- Pointer at 2, only requesters 0 and 1 valid -> requester 0 granted first, then 1.
- rst_n pulsed low during the sweep at addr 5 -> outputs zero immediately; sweep restarts at addr 0; full 8 writes follow.
- Requester 0 writes addr=0, data=0x1234 -> with REGFILE_ARB_R0_PROTECT_EN: accepted but rf_wr_en stays 0; without it: rf_wr_en=1, addr=0, data=0x1234.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Register file write-port owner: clears all registers after reset, then grants
// NUM_REQ write-back requesters round-robin. Optional macro REGFILE_ARB_R0_PROTECT_EN
// keeps register 0 at zero by suppressing arbitrated writes to address 0.
module regfile_write_arbiter #(
  parameter  int BUS_WIDTH = 16,
  parameter  int DEPTH     = 8,
  parameter  int NUM_REQ   = 3,
  localparam int ADDR_SIZE = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*ADDR_SIZE-1:0]   req_addr,
  input  logic [NUM_REQ*BUS_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           rf_wr_en,
  output logic [ADDR_SIZE-1:0]           rf_wr_addr,
  output logic [BUS_WIDTH-1:0]           rf_wr_data,
  output logic                           init_done
);
  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic {INIT, ARB} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_SIZE-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic                   en_q, en_d;
  logic [ADDR_SIZE-1:0]   addr_q, addr_d;
  logic [BUS_WIDTH-1:0]   data_q, data_d;
  logic                   done_q, done_d;

  logic [NUM_REQ-1:0]     gnt;
  logic [PTR_W-1:0]       gnt_idx;
  logic                   found;
  logic [ADDR_SIZE-1:0]   sel_addr;
  logic [BUS_WIDTH-1:0]   sel_data;

  // First valid requester at or above the pointer, wrapping; depends only on
  // state, pointer and valid so ready never combinationally follows addr/data.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    if (state_q == ARB) begin
      for (int off = 0; off < NUM_REQ; off++) begin
        if (!found && req_valid[(int'(ptr_q) + off) % NUM_REQ]) begin
          found   = 1'b1;
          gnt_idx = PTR_W'((int'(ptr_q) + off) % NUM_REQ);
          gnt[(int'(ptr_q) + off) % NUM_REQ] = 1'b1;
        end
      end
    end
  end

  assign sel_addr  = req_addr[gnt_idx*ADDR_SIZE +: ADDR_SIZE];
  assign sel_data  = req_data[gnt_idx*BUS_WIDTH +: BUS_WIDTH];
  assign req_ready = gnt;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    en_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = done_q;
    if (state_q == INIT) begin
      en_d   = 1'b1;
      addr_d = cnt_q;
      data_d = '0;
      cnt_d  = cnt_q + ADDR_SIZE'(1);
      if (cnt_q == ADDR_SIZE'(DEPTH - 1)) begin
        state_d = ARB;
        done_d  = 1'b1;
      end
    end else if (found) begin
`ifdef REGFILE_ARB_R0_PROTECT_EN
      en_d   = (sel_addr != '0);
`else
      en_d   = 1'b1;
`endif
      addr_d = sel_addr;
      data_d = sel_data;
      ptr_d  = PTR_W'((int'(gnt_idx) + 1) % NUM_REQ);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
      ptr_q   <= '0;
      en_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign rf_wr_en   = en_q;
  assign rf_wr_addr = addr_q;
  assign rf_wr_data = data_q;
  assign init_done  = done_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: expected write-port values are queued
// when each step is driven and popped after the edge that produces them.
module tb_regfile_write_arbiter;
  localparam int BW = 16;
  localparam int AW = 3;
  localparam int NR = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*BW-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            rf_wr_en;
  logic [AW-1:0]   rf_wr_addr;
  logic [BW-1:0]   rf_wr_data;
  logic            init_done;

  logic [AW-1:0] a0, a1, a2;
  logic [BW-1:0] d0, d1, d2;
  assign req_addr = {a2, a1, a0};
  assign req_data = {d2, d1, d0};

  typedef struct {
    logic          en;
    bit            chk_ad;
    logic [AW-1:0] addr;
    logic [BW-1:0] data;
  } exp_t;
  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;

  regfile_write_arbiter #(.BUS_WIDTH(BW), .DEPTH(8), .NUM_REQ(NR)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .rf_wr_en(rf_wr_en),
    .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data), .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; drives valid, checks ready, queues the expected
  // write-port state, then checks it after the rising edge and returns at the
  // next falling edge.
  task automatic step(input string tag, input logic [NR-1:0] v, input logic [NR-1:0] exp_rdy,
                      input logic exp_en, input logic [AW-1:0] exp_a, input logic [BW-1:0] exp_d,
                      input bit chk_ad);
    exp_t e, got;
    req_valid = v;
    #1;
    chk({tag, "_ready"}, 64'(req_ready), 64'(exp_rdy));
    e.en = exp_en; e.chk_ad = chk_ad; e.addr = exp_a; e.data = exp_d;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      got = sb.pop_front();
      chk({tag, "_en"}, 64'(rf_wr_en), 64'(got.en));
      if (got.chk_ad) begin
        chk({tag, "_addr"}, 64'(rf_wr_addr), 64'(got.addr));
        chk({tag, "_data"}, 64'(rf_wr_data), 64'(got.data));
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    a0 = 3'd1; a1 = 3'd3; a2 = 3'd4;
    d0 = 16'hA0A0; d1 = 16'hBEEF; d2 = 16'hC2C2;
    repeat (2) @(negedge clk);
    req_valid = 3'b111;
    #1;
    chk("rst_en", 64'(rf_wr_en), 64'd0);
    chk("rst_addr", 64'(rf_wr_addr), 64'd0);
    chk("rst_data", 64'(rf_wr_data), 64'd0);
    chk("rst_done", 64'(init_done), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);

    // Partial sweep up to address 5, then asynchronous reset mid-sweep.
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step("sweep_a", 3'b111, 3'b000, 1'b1, AW'(i), 16'h0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_en", 64'(rf_wr_en), 64'd0);
    chk("midrst_addr", 64'(rf_wr_addr), 64'd0);
    chk("midrst_done", 64'(init_done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full sweep with every requester valid; ready must stay low.
    for (int i = 0; i < 8; i++) begin
      step("sweep_b", 3'b111, 3'b000, 1'b1, AW'(i), 16'h0, 1'b1);
      chk("sweep_done", 64'(init_done), (i == 7) ? 64'd1 : 64'd0);
    end

    // Single requester 1: addr 3, 0xBEEF; then idle holds addr/data.
    step("r1", 3'b010, 3'b010, 1'b1, 3'd3, 16'hBEEF, 1'b1);
    step("idle1", 3'b000, 3'b000, 1'b0, 3'd3, 16'hBEEF, 1'b1);

    // Pointer at 2 with only 0 and 1 valid: 0 first, then 1.
    step("p2_r0", 3'b011, 3'b001, 1'b1, 3'd1, 16'hA0A0, 1'b1);
    step("p2_r1", 3'b010, 3'b010, 1'b1, 3'd3, 16'hBEEF, 1'b1);
    step("r2", 3'b100, 3'b100, 1'b1, 3'd4, 16'hC2C2, 1'b1);

    // All valid from pointer 0: grants rotate 0,1,2,0,1,2 back-to-back.
    a0 = 3'd1; a1 = 3'd2; a2 = 3'd4;
    for (int k = 0; k < 6; k++) begin
      case (k % 3)
        0: step("rr", 3'b111, 3'b001, 1'b1, 3'd1, 16'hA0A0, 1'b1);
        1: step("rr", 3'b111, 3'b010, 1'b1, 3'd2, 16'hBEEF, 1'b1);
        default: step("rr", 3'b111, 3'b100, 1'b1, 3'd4, 16'hC2C2, 1'b1);
      endcase
    end
    step("idle2", 3'b000, 3'b000, 1'b0, 3'd4, 16'hC2C2, 1'b1);

    // Requester 0 writes register 0.
    a0 = 3'd0; d0 = 16'h1234;
`ifdef REGFILE_ARB_R0_PROTECT_EN
    step("r0w", 3'b001, 3'b001, 1'b0, 3'd0, 16'h1234, 1'b0);
`else
    step("r0w", 3'b001, 3'b001, 1'b1, 3'd0, 16'h1234, 1'b1);
`endif
    // Pointer advanced past 0 regardless of protection.
    step("r0_next", 3'b011, 3'b010, 1'b1, 3'd2, 16'hBEEF, 1'b1);
    step("idle3", 3'b000, 3'b000, 1'b0, 3'd2, 16'hBEEF, 1'b1);
    chk("done_held", 64'(init_done), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
